// File: rtl/lock_entry_ctrl_if.sv
// -----------------------------------------------------------------------------
// lock_entry_ctrl_if
//
// Purpose:
//   Groups the key-pad strobes, the comparator link and the status outputs of
//   lock_entry_ctrl into one bundle.
//
// Signals:
//   key_valid  : one-cycle strobe, a bit key was pressed
//   key_bit    : value of the pressed key, qualified by key_valid
//   key_clear  : one-cycle strobe, discard the partial code
//   match      : comparator output y, sampled only in CHECK
//   code       : assembled code, drives comparator input i
//   code_valid : high for the single CHECK cycle
//   unlocked   : high while the lock is open
//   lockout    : high while further attempts are blocked
//   fail_cnt   : consecutive mismatch count
//   bit_cnt    : bits entered so far
//
// Modports:
//   master : key pad / comparator side (drives keys and match)
//   slave  : lock_entry_ctrl side (drives code and status)
// -----------------------------------------------------------------------------
interface lock_entry_ctrl_if #(
   parameter int CODE_W = 4
);

   logic              key_valid;
   logic              key_bit;
   logic              key_clear;
   logic              match;
   logic [CODE_W-1:0] code;
   logic              code_valid;
   logic              unlocked;
   logic              lockout;
   logic [1:0]        fail_cnt;
   logic [2:0]        bit_cnt;

   modport master (
      output key_valid,
      output key_bit,
      output key_clear,
      output match,
      input  code,
      input  code_valid,
      input  unlocked,
      input  lockout,
      input  fail_cnt,
      input  bit_cnt
   );

   modport slave (
      input  key_valid,
      input  key_bit,
      input  key_clear,
      input  match,
      output code,
      output code_valid,
      output unlocked,
      output lockout,
      output fail_cnt,
      output bit_cnt
   );

endinterface : lock_entry_ctrl_if

// File: rtl/lock_entry_ctrl.sv
// -----------------------------------------------------------------------------
// lock_entry_ctrl
//
// Purpose:
//   Sequential front end for the combinational code comparator `lock`.
//   Serial bit keys are shifted in MSB first until CODE_W bits are collected.
//   The finished code is held on bus.code for one CHECK cycle while the
//   comparator result bus.match is sampled. A match opens the lock for
//   OPEN_CYCLES cycles; MAX_FAILS consecutive mismatches block all keys for
//   LOCKOUT_CYCLES cycles.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : lock_entry_ctrl_if.slave (keys, comparator link, status outputs)
//
// Optional feature (macro LOCK_ENTRY_TIMEOUT_EN):
//   When defined, a partial entry is abandoned after TIMEOUT_CYCLES cycles
//   without a key press; fail_cnt is left untouched. When undefined, ENTRY
//   waits indefinitely and no inactivity logic is built.
//
// All outputs come straight from registers; there is no combinational path
// from the key inputs to any output.
// -----------------------------------------------------------------------------
module lock_entry_ctrl #(
   parameter int CODE_W         = 4,
   parameter int OPEN_CYCLES    = 8,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   lock_entry_ctrl_if.slave  bus
);

   // ---------------------------------------------------------------------------
   // Timer sizing: one down-counter is shared by OPEN, LOCKOUT and (optionally)
   // the ENTRY inactivity limit, since those states are mutually exclusive.
   // ---------------------------------------------------------------------------
   localparam int MAX_OL  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
   localparam int MAX_CYC = (MAX_OL > TIMEOUT_CYCLES) ? MAX_OL : TIMEOUT_CYCLES;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TMR_W-1:0] OPEN_LOAD    = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_ENTRY_TIMEOUT_EN
   localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

   // ---------------------------------------------------------------------------
   // State encoding
   // ---------------------------------------------------------------------------
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTRY   = 3'd1;
   localparam logic [2:0] S_CHECK   = 3'd2;
   localparam logic [2:0] S_OPEN    = 3'd3;
   localparam logic [2:0] S_LOCKOUT = 3'd4;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   logic [2:0]        r_state;
   logic [CODE_W-1:0] r_code;
   logic              r_code_valid;
   logic              r_unlocked;
   logic              r_lockout;
   logic [1:0]        r_fail_cnt;
   logic [2:0]        r_bit_cnt;
   logic [TMR_W-1:0]  r_timer;

   // ---------------------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------------------
   // The key arriving now completes the code.
   logic w_last_bit;
   // This mismatch reaches the failure limit.
   logic w_fail_limit;
   // Shared down-counter has expired.
   logic w_timer_done;

   assign w_last_bit   = (r_bit_cnt == 3'(CODE_W - 1));
   assign w_fail_limit = ((int'(r_fail_cnt) + 1) == MAX_FAILS);
   assign w_timer_done = (r_timer == '0);

   // ---------------------------------------------------------------------------
   // Control FSM and datapath
   // ---------------------------------------------------------------------------
   // NOTE: every register here is a flop updated with non-blocking (<=)
   // assignments so that all of them sample the pre-edge values together;
   // each one also has an explicit reset value so no state survives rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_code       <= '0;
         r_code_valid <= 1'b0;
         r_unlocked   <= 1'b0;
         r_lockout    <= 1'b0;
         r_fail_cnt   <= 2'd0;
         r_bit_cnt    <= 3'd0;
         r_timer      <= '0;
      end else begin
         // code_valid is a single-cycle pulse; it is only re-asserted on the
         // edge that enters CHECK.
         r_code_valid <= 1'b0;

         case (r_state)
            // -------------------------------------------------------------------
            S_IDLE: begin
               // First key starts a fresh code; key_clear alone does nothing.
               if (bus.key_valid) begin
                  r_code    <= {{(CODE_W-1){1'b0}}, bus.key_bit};
                  r_bit_cnt <= 3'd1;
                  r_state   <= S_ENTRY;
`ifdef LOCK_ENTRY_TIMEOUT_EN
                  r_timer   <= TIMEOUT_LOAD;
`endif
               end
            end

            // -------------------------------------------------------------------
            S_ENTRY: begin
               if (bus.key_clear) begin
                  // Clear has priority over a simultaneous key press.
                  r_code    <= '0;
                  r_bit_cnt <= 3'd0;
                  r_state   <= S_IDLE;
               end else if (bus.key_valid) begin
                  r_code    <= {r_code[CODE_W-2:0], bus.key_bit};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef LOCK_ENTRY_TIMEOUT_EN
                  r_timer   <= TIMEOUT_LOAD;
`endif
                  // The completing key moves straight to CHECK so that
                  // code_valid appears one cycle after it.
                  if (w_last_bit) begin
                     r_state      <= S_CHECK;
                     r_code_valid <= 1'b1;
                  end
               end
`ifdef LOCK_ENTRY_TIMEOUT_EN
               else if (w_timer_done) begin
                  // Abandoned entry: not a failed attempt.
                  r_code    <= '0;
                  r_bit_cnt <= 3'd0;
                  r_state   <= S_IDLE;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
`endif
            end

            // -------------------------------------------------------------------
            S_CHECK: begin
               // code has been stable all cycle, so the comparator output
               // is settled here. Keys are ignored.
               r_code    <= '0;
               r_bit_cnt <= 3'd0;
               if (bus.match) begin
                  r_fail_cnt <= 2'd0;
                  r_unlocked <= 1'b1;
                  r_timer    <= OPEN_LOAD;
                  r_state    <= S_OPEN;
               end else if (w_fail_limit) begin
                  r_fail_cnt <= 2'(MAX_FAILS);
                  r_lockout  <= 1'b1;
                  r_timer    <= LOCKOUT_LOAD;
                  r_state    <= S_LOCKOUT;
               end else begin
                  r_fail_cnt <= r_fail_cnt + 2'd1;
                  r_state    <= S_IDLE;
               end
            end

            // -------------------------------------------------------------------
            S_OPEN: begin
               // Timer was loaded with N-1, so the state lasts N cycles.
               // Keys neither shift nor restart the hold time.
               if (w_timer_done) begin
                  r_unlocked <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end

            // -------------------------------------------------------------------
            S_LOCKOUT: begin
               if (w_timer_done) begin
                  r_lockout  <= 1'b0;
                  r_fail_cnt <= 2'd0;
                  r_state    <= S_IDLE;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end

            // -------------------------------------------------------------------
            default: begin
               // Unreachable encodings recover to a safe, locked state.
               r_code     <= '0;
               r_bit_cnt  <= 3'd0;
               r_unlocked <= 1'b0;
               r_lockout  <= 1'b0;
               r_timer    <= '0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (registered)
   // ---------------------------------------------------------------------------
   assign bus.code       = r_code;
   assign bus.code_valid = r_code_valid;
   assign bus.unlocked   = r_unlocked;
   assign bus.lockout    = r_lockout;
   assign bus.fail_cnt   = r_fail_cnt;
   assign bus.bit_cnt    = r_bit_cnt;

endmodule : lock_entry_ctrl
